snow64_bfloat16_vec_cast_from_int: RTL and testbench

SNOW64_BFLOAT16_VEC_CAST_FROM_INT -- requirements
Module: snow64_bfloat16_vec_cast_from_int

---
 rtl/snow64_bfloat16_vec_cast_from_int_pkg.sv | 83 ++++++++
 rtl/snow64_bfloat16_vec_cast_from_int_cast.sv | 119 +++++++++++
 rtl/snow64_bfloat16_vec_cast_from_int.sv | 145 ++++++++++++++
 tb/tb_snow64_bfloat16_vec_cast_from_int.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/snow64_bfloat16_vec_cast_from_int_pkg.sv
// ----------------------------------------------------------------------------
// Shared types for the BFloat16 vector int-to-float cast.
//
// PkgSnow64Cpu      : CPU-wide integer element size encoding (IntTypSz).
// PkgSnow64BFloat16 : port bundles for the vector and scalar cast units,
//                     lane-count constants, state enums and a helper that
//                     maps an element size to the index of its last lane.
// ----------------------------------------------------------------------------
package PkgSnow64Cpu;

    typedef enum logic [1:0] {
        IntTypSz8  = 2'd0,
        IntTypSz16 = 2'd1,
        IntTypSz32 = 2'd2,
        IntTypSz64 = 2'd3
    } IntTypSz;

endpackage : PkgSnow64Cpu

package PkgSnow64BFloat16;
    import PkgSnow64Cpu::*;

    localparam int WidthVec       = 256;
    localparam int WidthBFloat16  = 16;
    localparam int WidthScalarInt = 64;

    // Number of lanes in a 256-bit vector for each element size.  Sz8 only
    // fills the lower half because the output lanes are always 16 bits wide.
    localparam int LaneCntSz8  = 16;
    localparam int LaneCntSz16 = 16;
    localparam int LaneCntSz32 = 8;
    localparam int LaneCntSz64 = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } StVecCast;

    typedef enum logic {
        StCastIdle,
        StCastBusy
    } StCast;

    typedef struct packed {
        logic                start;
        logic [WidthVec-1:0] data;
        IntTypSz             int_type_size;
        logic                type_signedness;
    } PortIn_VecCastFromInt;

    typedef struct packed {
        logic                valid;
        logic                can_accept_cmd;
        logic [WidthVec-1:0] data;
    } PortOut_VecCastFromInt;

    typedef struct packed {
        logic                      start;
        logic [WidthScalarInt-1:0] data;
        IntTypSz                   int_type_size;
        logic                      type_signedness;
    } PortIn_CastFromInt;

    typedef struct packed {
        logic                     valid;
        logic                     can_accept_cmd;
        logic [WidthBFloat16-1:0] data;
    } PortOut_CastFromInt;

    // Index of the final lane processed for a given element size.
    function automatic logic [3:0] lastLaneIdx(input IntTypSz sz);
        logic [3:0] idx;
        case (sz)
            IntTypSz8:  idx = 4'(LaneCntSz8 - 1);
            IntTypSz16: idx = 4'(LaneCntSz16 - 1);
            IntTypSz32: idx = 4'(LaneCntSz32 - 1);
            default:    idx = 4'(LaneCntSz64 - 1);
        endcase
        return idx;
    endfunction

endpackage : PkgSnow64BFloat16

// File: rtl/snow64_bfloat16_vec_cast_from_int_cast.sv
// ----------------------------------------------------------------------------
// Snow64BFloat16CastFromInt: scalar integer to BFloat16 cast unit.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   i_start             : command request, taken when o_can_accept_cmd=1
//   i_data[63:0]        : element, zero-extended from its natural width
//   i_int_type_size     : element width (IntTypSz8/16/32/64)
//   i_type_signedness   : 1 = element is two's complement signed
//   o_valid             : one-cycle pulse, result available on o_data
//   o_can_accept_cmd    : unit is idle
//   o_data[15:0]        : BFloat16 result (held until the next command)
//
// The mantissa is truncated, never rounded.  A command produces o_valid on
// the cycle after it is accepted; the unit then needs one recovery cycle.
// ----------------------------------------------------------------------------
module Snow64BFloat16CastFromInt
    import PkgSnow64Cpu::*;
    import PkgSnow64BFloat16::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [63:0] i_data,
    input  IntTypSz     i_int_type_size,
    input  logic        i_type_signedness,
    output logic        o_valid,
    output logic        o_can_accept_cmd,
    output logic [15:0] o_data
);

    StCast       r_state;
    logic        r_valid;
    logic        r_canAccept;
    logic [15:0] r_data;

    logic [63:0] w_mask;
    logic        w_msb;
    logic        w_neg;
    logic [63:0] w_elem;
    logic [63:0] w_mag;
    logic [5:0]  w_msbPos;
    logic [7:0]  w_exp;
    logic [6:0]  w_mant;
    logic [15:0] w_result;

    // Convert the element to sign + magnitude, locate the leading one and
    // build the BFloat16 word.  The magnitude is normalised so the leading
    // one sits at bit 63; the seven bits below it become the mantissa.
    always_comb begin
        w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        w_msb  = i_data[63];
        case (i_int_type_size)
            IntTypSz8: begin
                w_mask = 64'h0000_0000_0000_00FF;
                w_msb  = i_data[7];
            end
            IntTypSz16: begin
                w_mask = 64'h0000_0000_0000_FFFF;
                w_msb  = i_data[15];
            end
            IntTypSz32: begin
                w_mask = 64'h0000_0000_FFFF_FFFF;
                w_msb  = i_data[31];
            end
            default: begin
                w_mask = 64'hFFFF_FFFF_FFFF_FFFF;
                w_msb  = i_data[63];
            end
        endcase

        w_neg  = i_type_signedness & w_msb;
        w_elem = i_data & w_mask;
        w_mag  = w_neg ? ((~w_elem + 64'd1) & w_mask) : w_elem;

        w_msbPos = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (w_mag[i]) begin
                w_msbPos = 6'(i);
            end
        end

        w_exp    = 8'd127 + {2'b00, w_msbPos};
        w_mant   = 7'((w_mag << (6'd63 - w_msbPos)) >> 56);
        w_result = (w_mag == 64'd0) ? 16'h0000 : {w_neg, w_exp, w_mant};
    end

    // Two-state handshake: accept in idle, pulse valid, recover for a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StCastIdle;
            r_valid     <= 1'b0;
            r_canAccept <= 1'b1;
            r_data      <= 16'h0000;
        end else begin
            case (r_state)
                StCastIdle: begin
                    r_valid <= 1'b0;
                    if (i_start) begin
                        r_data      <= w_result;
                        r_valid     <= 1'b1;
                        r_canAccept <= 1'b0;
                        r_state     <= StCastBusy;
                    end
                end
                default: begin
                    r_valid     <= 1'b0;
                    r_canAccept <= 1'b1;
                    r_state     <= StCastIdle;
                end
            endcase
        end
    end

    assign o_valid          = r_valid;
    assign o_can_accept_cmd = r_canAccept;
    assign o_data           = r_data;

endmodule : Snow64BFloat16CastFromInt

// File: rtl/snow64_bfloat16_vec_cast_from_int.sv
// ----------------------------------------------------------------------------
// snow64_bfloat16_vec_cast_from_int: 256-bit vector integer to BFloat16 cast.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_start                 : command request, sampled only when idle
//   in_data[255:0]           : packed integer lanes (width set by size)
//   in_int_type_size[1:0]    : element width (IntTypSz8/16/32/64)
//   in_type_signedness       : 1 = signed elements
//   out_valid                : result ready, held until next acceptance
//   out_can_accept_cmd       : idle, ready for in_start
//   out_data[255:0]          : packed BFloat16 lanes, lane i at [i*16 +: 16]
//
// Lanes are cast one at a time through a single scalar cast unit, three
// clock edges per lane (issue, cast, write back).
// ----------------------------------------------------------------------------
module snow64_bfloat16_vec_cast_from_int
    import PkgSnow64Cpu::*;
    import PkgSnow64BFloat16::*;
#(
    parameter int WIDTH__VEC = 256
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_start,
    input  logic [WIDTH__VEC-1:0] in_data,
    input  logic [1:0]            in_int_type_size,
    input  logic                  in_type_signedness,
    output logic                  out_valid,
    output logic                  out_can_accept_cmd,
    output logic [WIDTH__VEC-1:0] out_data
);

    PortIn_VecCastFromInt  w_portIn;
    PortOut_VecCastFromInt w_portOut;

    StVecCast              r_state;
    logic [3:0]            r_idx;
    logic [WidthVec-1:0]   r_data;
    IntTypSz               r_size;
    logic                  r_signed;
    logic                  r_valid;
    logic                  r_canAccept;
    logic [WidthVec-1:0]   r_outData;
    logic                  r_castStart;

    logic [63:0]           w_elem;
    logic                  w_castValid;
    logic                  w_castCanAccept;
    logic [15:0]           w_castData;

    assign w_portIn.start           = in_start;
    assign w_portIn.data            = in_data;
    assign w_portIn.int_type_size   = IntTypSz'(in_int_type_size);
    assign w_portIn.type_signedness = in_type_signedness;

    // Select the current lane's element from the captured vector and
    // zero-extend it; the cast unit applies sign handling itself.
    always_comb begin
        w_elem = 64'd0;
        case (r_size)
            IntTypSz8:  w_elem = {56'd0, r_data[{r_idx, 3'b000} +: 8]};
            IntTypSz16: w_elem = {48'd0, r_data[{r_idx, 4'b0000} +: 16]};
            IntTypSz32: w_elem = {32'd0, r_data[{r_idx[2:0], 5'b00000} +: 32]};
            default:    w_elem = r_data[{r_idx[1:0], 6'b000000} +: 64];
        endcase
    end

    Snow64BFloat16CastFromInt u_cast (
        .clk               (clk),
        .rst               (rst),
        .i_start           (r_castStart),
        .i_data            (w_elem),
        .i_int_type_size   (r_size),
        .i_type_signedness (r_signed),
        .o_valid           (w_castValid),
        .o_can_accept_cmd  (w_castCanAccept),
        .o_data            (w_castData)
    );

    // Command sequencer.  Start to the cast unit is a single-cycle pulse,
    // and issuing waits on the cast unit's ready so a unit left busy by a
    // mid-command reset is never overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_idx       <= 4'd0;
            r_data      <= '0;
            r_size      <= IntTypSz8;
            r_signed    <= 1'b0;
            r_valid     <= 1'b0;
            r_canAccept <= 1'b1;
            r_outData   <= '0;
            r_castStart <= 1'b0;
        end else begin
            r_castStart <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_portIn.start) begin
                        r_data      <= w_portIn.data;
                        r_size      <= w_portIn.int_type_size;
                        r_signed    <= w_portIn.type_signedness;
                        r_idx       <= 4'd0;
                        r_outData   <= '0;
                        r_valid     <= 1'b0;
                        r_canAccept <= 1'b0;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (w_castCanAccept) begin
                        r_castStart <= 1'b1;
                        r_state     <= StWait;
                    end
                end
                StWait: begin
                    if (w_castValid) begin
                        r_outData[{r_idx, 4'b0000} +: 16] <= w_castData;
                        if (r_idx == lastLaneIdx(r_size)) begin
                            r_valid     <= 1'b1;
                            r_canAccept <= 1'b1;
                            r_state     <= StIdle;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= StIssue;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_portOut.valid          = r_valid;
    assign w_portOut.can_accept_cmd = r_canAccept;
    assign w_portOut.data           = r_outData;

    assign out_valid          = w_portOut.valid;
    assign out_can_accept_cmd = w_portOut.can_accept_cmd;
    assign out_data           = w_portOut.data;

endmodule : snow64_bfloat16_vec_cast_from_int

// File: tb/tb_snow64_bfloat16_vec_cast_from_int.sv
// ----------------------------------------------------------------------------
// tb_snow64_bfloat16_vec_cast_from_int: directed and randomised commands
// against an arithmetic reference of the int-to-BFloat16 conversion.
// ----------------------------------------------------------------------------
module tb_snow64_bfloat16_vec_cast_from_int;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic [255:0] in_data;
    logic [1:0]   in_int_type_size;
    logic         in_type_signedness;
    logic         out_valid;
    logic         out_can_accept_cmd;
    logic [255:0] out_data;

    int errors = 0;
    int checks = 0;

    snow64_bfloat16_vec_cast_from_int dut (
        .clk                (clk),
        .rst                (rst),
        .in_start           (in_start),
        .in_data            (in_data),
        .in_int_type_size   (in_int_type_size),
        .in_type_signedness (in_type_signedness),
        .out_valid          (out_valid),
        .out_can_accept_cmd (out_can_accept_cmd),
        .out_data           (out_data)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Number of lanes converted for an element size code.
    function automatic int laneCount(input logic [1:0] sz);
        case (sz)
            2'd0, 2'd1: return 16;
            2'd2:       return 8;
            default:    return 4;
        endcase
    endfunction

    // Reference conversion: take each element as an integer, split into sign
    // and magnitude, find floor(log2(magnitude)) by repeated halving, and
    // keep the seven bits below the leading one.
    function automatic logic [255:0] model(input logic [255:0] d, input logic [1:0] sz, input logic sgn);
        logic [255:0] res;
        logic [255:0] shifted;
        logic [63:0]  raw;
        logic [63:0]  mask;
        logic [63:0]  mag;
        logic [63:0]  tmp;
        logic [63:0]  mant;
        logic         neg;
        int           w;
        int           n;
        int           p;
        res = '0;
        n   = laneCount(sz);
        w   = 8 << sz;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        for (int i = 0; i < n; i++) begin
            shifted = d >> (i * w);
            raw     = shifted[63:0] & mask;
            neg     = sgn && raw[w-1];
            mag     = neg ? ((~raw + 64'd1) & mask) : raw;
            if (mag != 64'd0) begin
                p   = 0;
                tmp = mag;
                while (tmp > 64'd1) begin
                    tmp = tmp / 64'd2;
                    p++;
                end
                mant = (p >= 7) ? ((mag >> (p - 7)) & 64'h7F) : ((mag << (7 - p)) & 64'h7F);
                res[i*16 +: 16] = {neg, 8'(127 + p), mant[6:0]};
            end
        end
        return res;
    endfunction

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge, then scramble in_data so any late use
    // of the live input bus would corrupt the result.
    task automatic applyStimulus(input logic [255:0] d, input logic [1:0] sz, input logic sgn);
        in_data            = d;
        in_int_type_size   = sz;
        in_type_signedness = sgn;
        in_start           = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Count edges until out_valid, giving up after a fixed budget.
    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Full command: issue, wait, check latency and every lane.
    task automatic runAndCheck(input string tag, input logic [255:0] d, input logic [1:0] sz, input logic sgn);
        int lat;
        logic [255:0] exp;
        exp = model(d, sz, sgn);
        applyStimulus(d, sz, sgn);
        waitValid(lat);
        checkOutput({tag, "_latency"}, 256'(lat), 256'(3 * laneCount(sz)));
        checkOutput({tag, "_data"}, out_data, exp);
    endtask

    // Directed scenarios followed by randomised commands.
    initial begin
        logic [255:0] d;
        logic [255:0] dB;
        logic [255:0] expHeld;
        logic [1:0]   sz;
        logic         sgn;
        int           lat;

        rst                = 1'b1;
        in_start           = 1'b0;
        in_data            = '0;
        in_int_type_size   = 2'd0;
        in_type_signedness = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_accept", 256'(out_can_accept_cmd), 256'(1));
        checkOutput("reset_data", out_data, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Sz16 signed: 1, -1, 257, 0.
        d = '0;
        d[15:0]  = 16'h0001;
        d[31:16] = 16'hFFFF;
        d[47:32] = 16'h0101;
        runAndCheck("sz16_signed", d, 2'd1, 1'b1);
        checkOutput("sz16_signed_const", out_data, {192'd0, 16'h0000, 16'h4380, 16'hBF80, 16'h3F80});

        // Held result stays put while idle.
        expHeld = out_data;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held_valid", 256'(out_valid), 256'(1));
        checkOutput("held_data", out_data, expHeld);

        // Sz8 0xFF lanes with junk in the ignored upper half.
        d = {{16{8'hAA}}, {16{8'hFF}}};
        runAndCheck("sz8_unsigned", d, 2'd0, 1'b0);
        checkOutput("sz8_unsigned_const", out_data, {16{16'h437F}});
        runAndCheck("sz8_signed", d, 2'd0, 1'b1);
        checkOutput("sz8_signed_const", out_data, {16{16'hBF80}});

        // Sz64 signed: 2^40, -1, 3, 0.
        d = {64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0100_0000_0000};
        runAndCheck("sz64_signed", d, 2'd3, 1'b1);
        checkOutput("sz64_signed_const", out_data, {192'd0, 16'h0000, 16'h4040, 16'hBF80, 16'h5380});

        // Reset while lane 5 of an Sz32 command is in flight.
        d = {8{32'h1234_5678}};
        applyStimulus(d, 2'd2, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset_valid", 256'(out_valid), 256'(0));
        checkOutput("midreset_accept", 256'(out_can_accept_cmd), 256'(1));
        checkOutput("midreset_data", out_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        d = {8{32'd1}};
        runAndCheck("after_reset_sz32", d, 2'd2, 1'b1);
        checkOutput("after_reset_const", out_data, {128'd0, {8{16'h3F80}}});

        // A start pulse mid-command must not disturb the running command.
        d  = {16{16'h8001}};
        dB = {4{64'h0000_0000_0000_0003}};
        applyStimulus(d, 2'd1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        in_data            = dB;
        in_int_type_size   = 2'd3;
        in_type_signedness = 1'b0;
        in_start           = 1'b1;
        @(posedge clk);
        #1;
        in_start = 1'b0;
        waitValid(lat);
        checkOutput("ignored_start_latency", 256'(lat + 6), 256'(48));
        checkOutput("ignored_start_data", out_data, model(d, 2'd1, 1'b1));

        // Back-to-back command in the out_valid cycle.
        d = {8{32'hFFFF_FF80}};
        applyStimulus(d, 2'd2, 1'b1);
        checkOutput("b2b_valid_fall", 256'(out_valid), 256'(0));
        waitValid(lat);
        checkOutput("b2b_latency", 256'(lat), 256'(24));
        checkOutput("b2b_data", out_data, model(d, 2'd2, 1'b1));

        // Randomised commands with magnitudes spread across all widths.
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 8; j++) begin
                d[j*32 +: 32] = $urandom >> $urandom_range(0, 31);
            end
            if (k % 4 == 0) begin
                d[31:0] = 32'd0;
            end
            sz  = 2'($urandom_range(0, 3));
            sgn = 1'($urandom_range(0, 1));
            runAndCheck($sformatf("random_%0d", k), d, sz, sgn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_snow64_bfloat16_vec_cast_from_int
